// File: rtl/cp0_intr_unit_if.sv
// cp0_intr_unit_if: MEM-stage pipeline <-> CP0 interrupt unit signal bundle
//  master: pipeline side (drives pc, hwint, a, din, we, exl_clr; reads dout, epc, int_req)
//  slave : CP0 side (the reverse)
interface cp0_intr_unit_if;
   logic [31:0] pc;
   logic [5:0]  hwint;
   logic [4:0]  a;
   logic [31:0] din;
   logic        we;
   logic        exl_clr;
   logic [31:0] dout;
   logic [31:0] epc;
   logic        int_req;
   modport master (output pc, hwint, a, din, we, exl_clr, input dout, epc, int_req);
   modport slave  (input pc, hwint, a, din, we, exl_clr, output dout, epc, int_req);
endinterface

// File: rtl/cp0_intr_unit.sv
// cp0_intr_unit: MIPS coprocessor-0 interrupt unit (SR, Cause, EPC, PRId, interrupt request)
//  clk, reset : rising-edge clock, synchronous active-high reset
//  bus        : pc/hwint/a/din/we/exl_clr in; dout (mfc0), epc, int_req out
//  CP0_IP_LATCH_EN : when defined, Cause.IP bits are sticky and cleared by mtc0 to Cause
module cp0_intr_unit #(
   parameter logic [31:0] PRID = 32'h0000_2016
) (
   input logic         clk,
   input logic         reset,
   cp0_intr_unit_if.slave bus
);
   typedef enum logic [1:0] {RUN, HANDLER, GUARD} state_t;
   state_t      state, state_n;
   logic [5:0]  im, ip, ip_n;
   logic        exl, ie, take, wr_sr, wr_cause, wr_epc;
   logic [29:0] epc_q;
   // A taken interrupt flushes the MEM-stage instruction, so its mtc0 is suppressed.
   always_comb begin
      take     = |(ip & im) & ie & ~exl & (state == RUN);
      wr_sr    = bus.we & ~take & (bus.a == 5'd12);
      wr_cause = bus.we & ~take & (bus.a == 5'd13);
      wr_epc   = bus.we & ~take & (bus.a == 5'd14);
      state_n  = take                                                            ? HANDLER :
                 (state == RUN) && wr_sr && bus.din[1]                           ? HANDLER :
                 (state == HANDLER) && (bus.exl_clr || (wr_sr && !bus.din[1])) ? GUARD   :
                 (state == GUARD)                                                ? RUN     : state;
   end
`ifdef CP0_IP_LATCH_EN
   // Set beats clear when a device is still asserting while software acknowledges.
   assign ip_n = (wr_cause ? (ip & bus.din[15:10]) : ip) | bus.hwint;
`else
   assign ip_n = bus.hwint;
`endif
   always_ff @(posedge clk)
      state <= reset ? RUN : state_n;
   always_ff @(posedge clk) begin
      if (reset) begin
         im    <= '0;
         exl   <= 1'b0;
         ie    <= 1'b0;
         ip    <= '0;
         epc_q <= '0;
      end else begin
         ip <= ip_n;
         if (take) begin
            epc_q <= bus.pc[31:2];
            exl   <= 1'b1;
         end else begin
            if (wr_sr) begin
               im  <= bus.din[15:10];
               exl <= bus.din[1];
               ie  <= bus.din[0];
            end
            if ((state == HANDLER) && bus.exl_clr) exl <= 1'b0;
            if (wr_epc) epc_q <= bus.din[31:2];
         end
      end
   end
   assign bus.int_req = take;
   assign bus.epc     = {epc_q, 2'b00};
   assign bus.dout    = (bus.a == 5'd12) ? {16'b0, im, 8'b0, exl, ie} :
                        (bus.a == 5'd13) ? {16'b0, ip, 10'b0}         :
                        (bus.a == 5'd14) ? {epc_q, 2'b00}              :
                        (bus.a == 5'd15) ? PRID                        : 32'b0;
endmodule

// File: tb/tb_cp0_intr_unit.sv
// tb_cp0_intr_unit: directed and randomized checks of cp0_intr_unit against a register-level model
module tb_cp0_intr_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   cp0_intr_unit_if bus ();
   cp0_intr_unit #(.PRID(32'h0000_2016)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // Model: architectural register words plus a phase number (0 run, 1 handler, 2 guard).
   logic [31:0] m_sr, m_epc;
   logic [5:0]  m_ip;
   int          m_phase;
   function automatic logic m_req();
      return ((m_ip & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1] && (m_phase == 0);
   endfunction
   function automatic logic [31:0] m_rd(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return {16'b0, m_ip, 10'b0};
         5'd14:   return m_epc;
         5'd15:   return 32'h0000_2016;
         default: return 32'h0;
      endcase
   endfunction
   task automatic tick();
      logic        req, wr;
      logic [5:0]  ipn;
      @(posedge clk);
      if (reset) begin
         m_sr = 0; m_ip = 0; m_epc = 0; m_phase = 0;
      end else begin
         req = m_req();
         wr  = bus.we && !req;
`ifdef CP0_IP_LATCH_EN
         ipn = ((wr && bus.a == 5'd13) ? (m_ip & bus.din[15:10]) : m_ip) | bus.hwint;
`else
         ipn = bus.hwint;
`endif
         if (req) begin
            m_epc = {bus.pc[31:2], 2'b00};
            m_sr[1] = 1'b1;
            m_phase = 1;
         end else begin
            if (wr && bus.a == 5'd12) m_sr = bus.din & 32'h0000_FC03;
            if (wr && bus.a == 5'd14) m_epc = bus.din & 32'hFFFF_FFFC;
            if (m_phase == 0) begin
               if (wr && bus.a == 5'd12 && bus.din[1]) m_phase = 1;
            end else if (m_phase == 1) begin
               if (bus.exl_clr) begin
                  m_sr[1] = 1'b0;
                  m_phase = 2;
               end else if (wr && bus.a == 5'd12 && !bus.din[1]) m_phase = 2;
            end else m_phase = 0;
         end
         m_ip = ipn;
      end
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      bus.we = 0; bus.exl_clr = 0; bus.hwint = 0; bus.a = 0; bus.din = 0; bus.pc = 0;
      tick();
      reset = 1'b0;
   endtask
   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.a = a; bus.din = d; bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
   endtask
   task automatic test_reset();
      bus.hwint = 6'h3F; bus.pc = 32'hFFFF_FFFF;
      reset = 1'b1; tick(); reset = 1'b0;
      bus.hwint = 0; bus.a = 12; #1;
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h want %h", bus.dout, 32'h0); end
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b want 0", bus.int_req); end
      checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", bus.epc); end
   endtask
   task automatic test_take();
      mtc0(12, 32'h0000_0401);
      bus.hwint = 6'b000001; bus.pc = 32'h0000_3010; #1;
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL take_latency: got %b want 0", bus.int_req); end
      tick();
      checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL take_req: got %b want 1", bus.int_req); end
      tick();
      bus.a = 12; #1;
      checks++; if (bus.epc !== 32'h0000_3010) begin errors++; $display("FAIL take_epc: got %h want 00003010", bus.epc); end
      checks++; if (bus.dout !== 32'h0000_0403) begin errors++; $display("FAIL take_sr: got %h want 00000403", bus.dout); end
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL take_handler_req: got %b want 0", bus.int_req); end
   endtask
   task automatic test_guard();
      bus.exl_clr = 1'b1; tick(); bus.exl_clr = 1'b0;
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL guard_req: got %b want 0", bus.int_req); end
      tick();
      checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL guard_after: got %b want 1", bus.int_req); end
   endtask
   task automatic test_mask();
      do_reset();
      bus.hwint = 6'b000001;
      mtc0(12, 32'h0000_0001);
      bus.a = 13; #1;
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL mask_im_req: got %b want 0", bus.int_req); end
      checks++; if (bus.dout !== 32'h0000_0400) begin errors++; $display("FAIL mask_cause: got %h want 00000400", bus.dout); end
      mtc0(12, 32'h0000_0400);
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL mask_ie_req: got %b want 0", bus.int_req); end
   endtask
   task automatic test_take_beats_mtc0();
      do_reset();
      bus.hwint = 6'b000001;
      mtc0(12, 32'h0000_0401);
      checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", bus.int_req); end
      bus.pc = 32'h0000_5004;
      mtc0(12, 32'h0000_0000);
      bus.a = 12; #1;
      checks++; if (bus.dout !== 32'h0000_0403) begin errors++; $display("FAIL prio_sr: got %h want 00000403", bus.dout); end
      checks++; if (bus.epc !== 32'h0000_5004) begin errors++; $display("FAIL prio_epc: got %h want 00005004", bus.epc); end
   endtask
   task automatic test_regs();
      bus.a = 15; #1;
      checks++; if (bus.dout !== 32'h0000_2016) begin errors++; $display("FAIL prid: got %h want 00002016", bus.dout); end
      bus.a = 3; #1;
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL unmapped: got %h want 0", bus.dout); end
      bus.a = 14; bus.din = 32'h0000_3007; bus.we = 1'b1; #1;
      checks++; if (bus.dout !== 32'h0000_5004) begin errors++; $display("FAIL epc_prewrite: got %h want 00005004", bus.dout); end
      tick(); bus.we = 1'b0;
      checks++; if (bus.dout !== 32'h0000_3004) begin errors++; $display("FAIL epc_write: got %h want 00003004", bus.dout); end
   endtask
   task automatic test_eret_epc_write();
      bus.a = 14; bus.din = 32'h0000_8000; bus.we = 1'b1; bus.exl_clr = 1'b1; #1;
      checks++; if (bus.epc !== 32'h0000_3004) begin errors++; $display("FAIL eret_old_epc: got %h want 00003004", bus.epc); end
      tick(); bus.we = 1'b0; bus.exl_clr = 1'b0;
      checks++; if (bus.epc !== 32'h0000_8000) begin errors++; $display("FAIL eret_new_epc: got %h want 00008000", bus.epc); end
      checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL eret_guard: got %b want 0", bus.int_req); end
   endtask
   task automatic test_ip_pulse();
      do_reset();
      mtc0(12, 32'h0000_0400);
      bus.hwint = 6'b000001; tick(); bus.hwint = 6'b0;
      bus.a = 13; #1;
      checks++; if (bus.dout !== 32'h0000_0400) begin errors++; $display("FAIL ip_capture: got %h want 00000400", bus.dout); end
      tick();
`ifdef CP0_IP_LATCH_EN
      checks++; if (bus.dout !== 32'h0000_0400) begin errors++; $display("FAIL ip_sticky: got %h want 00000400", bus.dout); end
      mtc0(13, 32'h0);
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL ip_clear: got %h want 0", bus.dout); end
`else
      checks++; if (bus.dout !== 32'h0) begin errors++; $display("FAIL ip_follow: got %h want 0", bus.dout); end
`endif
   endtask
   task automatic test_random();
      int k;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         k = $urandom_range(0, 5);
         bus.a = (k < 2) ? 5'd12 : (k == 2) ? 5'd13 : (k == 3) ? 5'd14 : (k == 4) ? 5'd15 : 5'($urandom_range(0, 31));
         bus.din = $urandom;
         if ($urandom_range(0, 3) != 0) bus.din[1] = 1'b0;
         if ($urandom_range(0, 3) != 0) bus.din[0] = 1'b1;
         bus.we = ($urandom_range(0, 3) == 0);
         bus.exl_clr = ($urandom_range(0, 5) == 0);
         bus.hwint = $urandom_range(0, 1) ? 6'($urandom) : 6'b0;
         bus.pc = $urandom;
         #1;
         checks++; if (bus.dout !== m_rd(bus.a)) begin errors++; $display("FAIL rnd_dout[%0d] a=%0d: got %h want %h", i, bus.a, bus.dout, m_rd(bus.a)); end
         checks++; if (bus.int_req !== m_req()) begin errors++; $display("FAIL rnd_int_req[%0d]: got %b want %b", i, bus.int_req, m_req()); end
         checks++; if (bus.epc !== m_epc) begin errors++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, bus.epc, m_epc); end
         tick();
      end
      reset = 1'b0;
   endtask
   initial begin
      m_sr = 0; m_ip = 0; m_epc = 0; m_phase = 0;
      bus.we = 0; bus.exl_clr = 0; bus.hwint = 0; bus.a = 0; bus.din = 0; bus.pc = 0;
      test_reset();
      test_take();
      test_guard();
      test_mask();
      test_take_beats_mtc0();
      test_regs();
      test_eret_epc_write();
      test_ip_pulse();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
